// File: rtl/lcd_pkg.sv
// Shared LCD controller definitions: FSM state encoding and default bus phase timing.
// Used by both the LCD writer and the status reader.
package lcd_pkg;

  localparam int SETUP_CYC_DEF  = 2;
  localparam int E_HIGH_CYC_DEF = 12;
  localparam int HOLD_CYC_DEF   = 2;
  localparam int MAX_POLLS_DEF  = 255;

  localparam int TMR_W  = 8;
  localparam int POLL_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_E_HIGH = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // A phase of N cycles loads N-1 so the zero flag marks its last cycle.
  function automatic logic [TMR_W-1:0] phase_load(input int cyc);
    return TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/lcd_status_reader_if.sv
// Host request/response signals and LCD panel pins of the status reader.
interface lcd_status_reader_if;

  logic       req;
  logic       rs_sel;
  logic       poll;
  logic       ack;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       timeout;
  logic       rd_active;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA_IN;

  modport master (
    output req, rs_sel, poll, LCD_DATA_IN,
    input  ack, rd_data, busy_flag, addr_cnt, timeout, rd_active,
           LCD_E, LCD_RS, LCD_RW
  );

  modport slave (
    input  req, rs_sel, poll, LCD_DATA_IN,
    output ack, rd_data, busy_flag, addr_cnt, timeout, rd_active,
           LCD_E, LCD_RS, LCD_RW
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with a zero flag; times one LCD bus phase.
module lcd_phase_timer
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_value,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (!o_zero) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780-style LCD read cycle engine: single status/data reads and busy-flag polling.
//
// state   | meaning
// IDLE    | bus released, waiting for req
// SETUP   | RW=1, RS valid, E low
// E_HIGH  | E strobe high; panel byte captured on the last cycle
// HOLD    | E low, RW still high; decide on another poll
// DONE    | one-cycle ack, bus released
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int E_HIGH_CYC = E_HIGH_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int MAX_POLLS  = MAX_POLLS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  lcd_status_reader_if.slave bus
);

  localparam logic [TMR_W-1:0]  SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [TMR_W-1:0]  E_HIGH_LD = phase_load(E_HIGH_CYC);
  localparam logic [TMR_W-1:0]  HOLD_LD   = phase_load(HOLD_CYC);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);

  logic [2:0]        r_state;
  logic              r_rs;
  logic              r_poll;
  logic [POLL_W-1:0] r_poll_cnt;
  logic              r_timeout;
  logic [7:0]        r_rd_data;
  logic              r_bf;
  logic [6:0]        r_ac;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic             w_bf_poll;
  logic             w_poll_again;
  logic             w_active;

  // Still busy on a polled status read; only re-read while under the limit.
  assign w_bf_poll    = r_poll & ~r_rs & r_rd_data[7];
  assign w_poll_again = w_bf_poll & (r_poll_cnt < POLL_LAST);

  lcd_phase_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_zero  (w_tmr_zero)
  );

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = SETUP_LD;
    case (r_state)
      ST_IDLE:   w_tmr_load = bus.req;
      ST_SETUP: begin
        w_tmr_load = w_tmr_zero;
        w_tmr_val  = E_HIGH_LD;
      end
      ST_E_HIGH: begin
        w_tmr_load = w_tmr_zero;
        w_tmr_val  = HOLD_LD;
      end
      ST_HOLD:   w_tmr_load = w_tmr_zero & w_poll_again;
      default:   w_tmr_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rs       <= 1'b0;
      r_poll     <= 1'b0;
      r_poll_cnt <= '0;
      r_timeout  <= 1'b0;
      r_rd_data  <= '0;
      r_bf       <= 1'b0;
      r_ac       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_state    <= ST_SETUP;
            r_rs       <= bus.rs_sel;
            r_poll     <= bus.poll;
            r_poll_cnt <= '0;
            r_timeout  <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (w_tmr_zero) r_state <= ST_E_HIGH;
        end
        ST_E_HIGH: begin
          if (w_tmr_zero) begin
            r_state   <= ST_HOLD;
            r_rd_data <= bus.LCD_DATA_IN;
            if (!r_rs) begin
              r_bf <= bus.LCD_DATA_IN[7];
              r_ac <= bus.LCD_DATA_IN[6:0];
            end
          end
        end
        ST_HOLD: begin
          if (w_tmr_zero) begin
            if (w_poll_again) begin
              r_poll_cnt <= r_poll_cnt + POLL_W'(1);
              r_state    <= ST_SETUP;
            end else begin
              r_timeout <= w_bf_poll;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RW doubles as bus ownership, so E can only rise while RW is high.
  assign w_active = (r_state == ST_SETUP) | (r_state == ST_E_HIGH) | (r_state == ST_HOLD);

  assign bus.rd_active = w_active;
  assign bus.LCD_RW    = w_active;
  assign bus.LCD_RS    = w_active & r_rs;
  assign bus.LCD_E     = (r_state == ST_E_HIGH);
  assign bus.ack       = (r_state == ST_DONE);
  assign bus.rd_data   = r_rd_data;
  assign bus.busy_flag = r_bf;
  assign bus.addr_cnt  = r_ac;
  assign bus.timeout   = r_timeout;

endmodule
